spio_hss_multiplexer_retx_store: RTL and testbench
==================================================

// Module: spio_hss_multiplexer_retx_store
// PURPOSE
//  Parametrised go-back-N packet store for the HSS multiplexer frame assembler.
//  Buffers outgoing packets until acknowledged, re-issues on nak and, new in
//  this generation, on a programmable ack timeout. Reports occupancy and a
//  retransmit count to the register interface.
//  Sits between the packet input channel and frame issue.
// PARAMETERS
//  PKT_BITS  72  packet width
//  BUF_BITS  4   log2 buffer depth; usable capacity 2**BUF_BITS-1 packets
//  SEQ_BITS  7   frame sequence number width; must be >= BUF_BITS
//  TO_BITS   8   timeout counter width
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous, active-high reset
//  timeout    in   TO_BITS    ack timeout in cycles; 0 = timeout disabled
//  stop       in   1          stop accepting packets (one more may be taken)
//  cfc_rem    in   1          remote flow control; 0 blocks reads
//  vld_ack    in   1          ack valid: frames before ack_seq acknowledged
//  vld_nak    in   1          nak valid: implicit ack, resend from ack_seq
//  ack_seq    in   SEQ_BITS   ack/nak sequence number
//  pkt_data   in   PKT_BITS   incoming packet
//  pkt_vld    in   1          incoming valid
//  pkt_rdy    out  1          incoming ready (registered)
//  bpkt_seq   in   SEQ_BITS   sequence number of frame being assembled
//  bpkt_rq    in   1          frame issue requests a packet
//  bpkt_gt    out  1          request granted (1 cycle after bpkt_rq)
//  bpkt_pres  out  1          packet present in current frame
//  bpkt_data  out  PKT_BITS   packet at output pointer
//  empty      out  1          no unread packets (unacked ones may remain)
//  full       out  1          buffer full
//  occupancy  out  BUF_BITS   packets held (written, not yet acked) = bw-ba
//  retx_cnt   out  16         timeout retransmissions, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: pointers ba/br/bo/bw=0, timer=0; empty=1, full=0, pkt_rdy=0,
//   bpkt_gt=0, bpkt_pres=0, occupancy=0, retx_cnt=0. Packet RAM not reset.
//  Pointers BUF_BITS wide, wrap modulo 2**BUF_BITS.
//  Write: pkt_vld&pkt_rdy&!full -> mem[bw]<=pkt_data, bw++.
//  full = (ba == bw_next+1); empty = (br == bw), both registered from next-state.
//  pkt_rdy next = !full_next; while stop=1 it holds, except pkt_vld=1 clears it.
//  Read: bpkt_rq&unread&cfc_rem -> bo<=br, br++; bpkt_gt=1 next cycle.
//   bpkt_pres updates only on bpkt_rq cycles, to read success.
//   bpkt_data = mem[bo], combinational.
//  Seq map (2**BUF_BITS entries): every bpkt_rq cycle writes
//   map[bpkt_seq[BUF_BITS-1:0]] <= br, even if the read fails.
//  Ack: ack_seq==bpkt_seq -> ba<=br; else ba<=map[ack_seq].
//   Nak also does ba<=map[ack_seq].
//  br priority: vld_nak -> map[ack_seq]; else timeout fire -> ba; else read.
//   A read in a nak/timeout cycle is not granted.
//  Timer: cleared on reset, vld_ack, vld_nak, fire, or ba==br.
//   Otherwise increments each cycle.
//   Fires when timeout!=0 and timer==timeout-1 with ba!=br and no ack/nak:
//   br<=ba (resend all unacked), retx_cnt++ (saturating).
//  Simultaneous write+ack/nak/timeout: each pointer updates independently;
//   full computed from the new values.
//  rst mid-operation: everything returns to reset values next cycle;
//   buffered data is discarded, no retransmission follows.
// TESTING
//  1 reset; write 0xA,0xB,0xC; bpkt_rq x3 with cfc_rem=1
//    -> bpkt_gt each next cycle, data A,B,C, empty=1 after third.
//  2 BUF_BITS=4, write 15 with no ack -> full=1, pkt_rdy=0, occupancy=15;
//    ack with ack_seq==bpkt_seq -> full=0, pkt_rdy=1 next cycle.
//  3 issue seq 0..3 (A..D); nak ack_seq=1 -> next reads return B,C,D,
//    occupancy=3.
//  4 timeout=20, issue A,B, no ack -> 20 cycles later br rewinds,
//    retx_cnt=1, next read returns A; timeout=0 -> never fires.
//  5 stop=1 with pkt_rdy=1 -> next pkt_vld accepted, then pkt_rdy=0
//    until stop=0.
//  6 rst with occupancy=5 mid-read -> all outputs at reset values next cycle;
//    bpkt_gt=0, no timeout fires afterwards.

Source files
------------

// File: rtl/spio_hss_multiplexer_retx_store.sv
// spio_hss_multiplexer_retx_store: go-back-N packet store with nak and ack-timeout retransmission
module spio_hss_multiplexer_retx_store #(
    parameter int PKT_BITS = 72,
    parameter int BUF_BITS = 4,
    parameter int SEQ_BITS = 7,
    parameter int TO_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TO_BITS-1:0]  timeout,
    input  logic                stop,
    input  logic                cfc_rem,
    input  logic                vld_ack,
    input  logic                vld_nak,
    input  logic [SEQ_BITS-1:0] ack_seq,
    input  logic [PKT_BITS-1:0] pkt_data,
    input  logic                pkt_vld,
    output logic                pkt_rdy,
    input  logic [SEQ_BITS-1:0] bpkt_seq,
    input  logic                bpkt_rq,
    output logic                bpkt_gt,
    output logic                bpkt_pres,
    output logic [PKT_BITS-1:0] bpkt_data,
    output logic                empty,
    output logic                full,
    output logic [BUF_BITS-1:0] occupancy,
    output logic [15:0]         retx_cnt
);
    localparam int DEPTH = 1 << BUF_BITS;
    logic [PKT_BITS-1:0] mem [DEPTH];
    logic [BUF_BITS-1:0] seq_map [DEPTH];
    logic [BUF_BITS-1:0] ba, br, bo, bw, ba_n, br_n, bw_n, ack_ptr, nak_ptr;
    logic [TO_BITS-1:0]  timer;
    logic                wr, rd, fire, pkt_rdy_n;
    always_comb begin
        wr        = pkt_vld & pkt_rdy & ~full;
        nak_ptr   = seq_map[ack_seq[BUF_BITS-1:0]];
        ack_ptr   = (ack_seq == bpkt_seq) ? br : nak_ptr;
        fire      = (timeout != '0) && (timer == timeout - TO_BITS'(1)) && (ba != br) && !vld_ack && !vld_nak;
        rd        = bpkt_rq & ~empty & cfc_rem & ~vld_nak & ~fire;
        ba_n      = vld_nak ? nak_ptr : vld_ack ? ack_ptr : ba;
        br_n      = vld_nak ? nak_ptr : fire ? ba : rd ? br + BUF_BITS'(1) : br;
        bw_n      = wr ? bw + BUF_BITS'(1) : bw;
        pkt_rdy_n = stop ? (pkt_rdy & ~pkt_vld) : (ba_n != bw_n + BUF_BITS'(1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ba        <= '0;
            br        <= '0;
            bo        <= '0;
            bw        <= '0;
            timer     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            pkt_rdy   <= 1'b0;
            bpkt_gt   <= 1'b0;
            bpkt_pres <= 1'b0;
            retx_cnt  <= '0;
        end else begin
            ba        <= ba_n;
            br        <= br_n;
            bw        <= bw_n;
            bo        <= rd ? br : bo;
            empty     <= (br_n == bw_n);
            full      <= (ba_n == bw_n + BUF_BITS'(1));
            pkt_rdy   <= pkt_rdy_n;
            bpkt_gt   <= rd;
            bpkt_pres <= bpkt_rq ? rd : bpkt_pres;
            timer     <= (vld_ack | vld_nak | fire | (ba == br)) ? '0 : timer + TO_BITS'(1);
            retx_cnt  <= (fire && retx_cnt != 16'hFFFF) ? retx_cnt + 16'd1 : retx_cnt;
        end
    end
    // Packet RAM and sequence map carry no reset; their contents are only
    // meaningful behind the reset pointers.
    always_ff @(posedge clk) begin
        if (wr) mem[bw] <= pkt_data;
        if (bpkt_rq) seq_map[bpkt_seq[BUF_BITS-1:0]] <= br;
    end
    assign bpkt_data = mem[bo];
    assign occupancy = bw - ba;
endmodule

// File: tb/tb_spio_hss_multiplexer_retx_store.sv
// tb_spio_hss_multiplexer_retx_store: directed self-checking bench for the retransmit store
module tb_spio_hss_multiplexer_retx_store;
    logic        clk = 0, rst = 1;
    logic [7:0]  timeout = 0;
    logic        stop = 0, cfc_rem = 1, vld_ack = 0, vld_nak = 0;
    logic [6:0]  ack_seq = 0, bpkt_seq = 0;
    logic [71:0] pkt_data = 0;
    logic        pkt_vld = 0, pkt_rdy, bpkt_rq = 0, bpkt_gt, bpkt_pres, empty, full;
    logic [71:0] bpkt_data;
    logic [3:0]  occupancy;
    logic [15:0] retx_cnt;
    int checks = 0, errors = 0;

    spio_hss_multiplexer_retx_store dut (
        .clk(clk), .rst(rst), .timeout(timeout), .stop(stop), .cfc_rem(cfc_rem),
        .vld_ack(vld_ack), .vld_nak(vld_nak), .ack_seq(ack_seq), .pkt_data(pkt_data),
        .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .bpkt_seq(bpkt_seq), .bpkt_rq(bpkt_rq),
        .bpkt_gt(bpkt_gt), .bpkt_pres(bpkt_pres), .bpkt_data(bpkt_data), .empty(empty),
        .full(full), .occupancy(occupancy), .retx_cnt(retx_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1; timeout = 0; stop = 0; cfc_rem = 1; vld_ack = 0; vld_nak = 0;
        pkt_vld = 0; bpkt_rq = 0; ack_seq = 0; bpkt_seq = 0;
        tick;
        rst = 0;
        tick;
    endtask

    task automatic write(input logic [71:0] d);
        pkt_vld = 1; pkt_data = d;
        tick;
        pkt_vld = 0;
    endtask

    task automatic request(input logic [6:0] s);
        bpkt_rq = 1; bpkt_seq = s;
        tick;
        bpkt_rq = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        tick;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (pkt_rdy !== 1'b0) begin errors++; $display("FAIL reset_pkt_rdy got %b want 0", pkt_rdy); end
        checks++; if (bpkt_gt !== 1'b0 || bpkt_pres !== 1'b0) begin errors++; $display("FAIL reset_gt_pres got %b%b want 00", bpkt_gt, bpkt_pres); end
        checks++; if (occupancy !== 4'd0 || retx_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", occupancy, retx_cnt); end
        rst = 0;
        tick;
        checks++; if (pkt_rdy !== 1'b1) begin errors++; $display("FAIL rdy_after_reset got %b want 1", pkt_rdy); end
    endtask

    task automatic test_basic;
        logic [71:0] exp [3];
        exp = '{72'hA, 72'hB, 72'hC};
        do_reset;
        request(7'd0);
        checks++; if (bpkt_gt !== 1'b0 || bpkt_pres !== 1'b0) begin errors++; $display("FAIL empty_read got gt=%b pres=%b want 0 0", bpkt_gt, bpkt_pres); end
        for (int i = 0; i < 3; i++) write(exp[i]);
        checks++; if (empty !== 1'b0 || occupancy !== 4'd3) begin errors++; $display("FAIL basic_fill got empty=%b occ=%0d want 0 3", empty, occupancy); end
        cfc_rem = 0;
        request(7'd0);
        cfc_rem = 1;
        checks++; if (bpkt_gt !== 1'b0) begin errors++; $display("FAIL cfc_block got %b want 0", bpkt_gt); end
        for (int i = 0; i < 3; i++) begin
            request(7'(i));
            checks++;
            if (bpkt_gt !== 1'b1 || bpkt_pres !== 1'b1 || bpkt_data !== exp[i]) begin
                errors++; $display("FAIL basic_read%0d got gt=%b pres=%b data=%h want 1 1 %h", i, bpkt_gt, bpkt_pres, bpkt_data, exp[i]);
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b want 1", empty); end
    endtask

    task automatic test_full;
        do_reset;
        for (int i = 0; i < 15; i++) write(72'(100 + i));
        checks++; if (full !== 1'b1 || pkt_rdy !== 1'b0 || occupancy !== 4'd15) begin errors++; $display("FAIL full_set got full=%b rdy=%b occ=%0d want 1 0 15", full, pkt_rdy, occupancy); end
        write(72'hDEAD);
        checks++; if (occupancy !== 4'd15) begin errors++; $display("FAIL full_overwrite got occ=%0d want 15", occupancy); end
        for (int i = 0; i < 15; i++) begin
            request(7'(i));
            checks++;
            if (bpkt_gt !== 1'b1 || bpkt_data !== 72'(100 + i)) begin
                errors++; $display("FAIL full_read%0d got gt=%b data=%h want 1 %h", i, bpkt_gt, bpkt_data, 72'(100 + i));
            end
        end
        checks++; if (empty !== 1'b1 || full !== 1'b1) begin errors++; $display("FAIL full_unacked got empty=%b full=%b want 1 1", empty, full); end
        vld_ack = 1; ack_seq = 7'd15; bpkt_seq = 7'd15;
        tick;
        vld_ack = 0;
        checks++; if (full !== 1'b0 || pkt_rdy !== 1'b1 || occupancy !== 4'd0) begin errors++; $display("FAIL full_ack got full=%b rdy=%b occ=%0d want 0 1 0", full, pkt_rdy, occupancy); end
    endtask

    task automatic test_nak;
        logic [71:0] exp [4];
        exp = '{72'hA, 72'hB, 72'hC, 72'hD};
        do_reset;
        for (int i = 0; i < 4; i++) write(exp[i]);
        for (int i = 0; i < 4; i++) request(7'(i));
        checks++; if (bpkt_data !== 72'hD || empty !== 1'b1) begin errors++; $display("FAIL nak_pre got data=%h empty=%b want d 1", bpkt_data, empty); end
        vld_nak = 1; ack_seq = 7'd1; bpkt_seq = 7'd4;
        tick;
        vld_nak = 0;
        checks++; if (occupancy !== 4'd3 || empty !== 1'b0) begin errors++; $display("FAIL nak_occ got occ=%0d empty=%b want 3 0", occupancy, empty); end
        for (int i = 1; i < 4; i++) begin
            request(7'(3 + i));
            checks++;
            if (bpkt_gt !== 1'b1 || bpkt_data !== exp[i]) begin
                errors++; $display("FAIL nak_read%0d got gt=%b data=%h want 1 %h", i, bpkt_gt, bpkt_data, exp[i]);
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL nak_empty got %b want 1", empty); end
    endtask

    task automatic test_timeout;
        do_reset;
        timeout = 8'd20;
        write(72'hA);
        write(72'hB);
        request(7'd0);
        request(7'd1);
        checks++; if (bpkt_data !== 72'hB || empty !== 1'b1) begin errors++; $display("FAIL to_pre got data=%h empty=%b want b 1", bpkt_data, empty); end
        repeat (18) tick;
        checks++; if (retx_cnt !== 16'd0 || empty !== 1'b1) begin errors++; $display("FAIL to_early got retx=%0d empty=%b want 0 1", retx_cnt, empty); end
        tick;
        checks++; if (retx_cnt !== 16'd1 || empty !== 1'b0) begin errors++; $display("FAIL to_fire got retx=%0d empty=%b want 1 0", retx_cnt, empty); end
        timeout = 8'd0;
        request(7'd2);
        checks++; if (bpkt_gt !== 1'b1 || bpkt_data !== 72'hA) begin errors++; $display("FAIL to_reread got gt=%b data=%h want 1 a", bpkt_gt, bpkt_data); end
        repeat (300) tick;
        checks++; if (retx_cnt !== 16'd1) begin errors++; $display("FAIL to_disabled got retx=%0d want 1", retx_cnt); end
    endtask

    task automatic test_stop;
        do_reset;
        checks++; if (pkt_rdy !== 1'b1) begin errors++; $display("FAIL stop_pre got %b want 1", pkt_rdy); end
        stop = 1; pkt_vld = 1; pkt_data = 72'h55;
        tick;
        checks++; if (occupancy !== 4'd1 || pkt_rdy !== 1'b0) begin errors++; $display("FAIL stop_last got occ=%0d rdy=%b want 1 0", occupancy, pkt_rdy); end
        tick;
        checks++; if (occupancy !== 4'd1 || pkt_rdy !== 1'b0) begin errors++; $display("FAIL stop_block got occ=%0d rdy=%b want 1 0", occupancy, pkt_rdy); end
        pkt_vld = 0;
        tick;
        checks++; if (pkt_rdy !== 1'b0) begin errors++; $display("FAIL stop_hold got %b want 0", pkt_rdy); end
        stop = 0;
        tick;
        checks++; if (pkt_rdy !== 1'b1 || occupancy !== 4'd1) begin errors++; $display("FAIL stop_release got rdy=%b occ=%0d want 1 1", pkt_rdy, occupancy); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        timeout = 8'd20;
        for (int i = 0; i < 5; i++) write(72'(i + 1));
        request(7'd0);
        checks++; if (occupancy !== 4'd5 || bpkt_gt !== 1'b1) begin errors++; $display("FAIL mid_pre got occ=%0d gt=%b want 5 1", occupancy, bpkt_gt); end
        bpkt_rq = 1; bpkt_seq = 7'd1; rst = 1;
        tick;
        checks++;
        if (bpkt_gt !== 1'b0 || bpkt_pres !== 1'b0 || occupancy !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || pkt_rdy !== 1'b0 || retx_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_reset got gt=%b pres=%b occ=%0d empty=%b full=%b rdy=%b retx=%0d want 0 0 0 1 0 0 0",
                               bpkt_gt, bpkt_pres, occupancy, empty, full, pkt_rdy, retx_cnt);
        end
        rst = 0; bpkt_rq = 0;
        repeat (40) tick;
        checks++; if (retx_cnt !== 16'd0 || empty !== 1'b1 || occupancy !== 4'd0) begin errors++; $display("FAIL mid_after got retx=%0d empty=%b occ=%0d want 0 1 0", retx_cnt, empty, occupancy); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full;
        test_nak;
        test_timeout;
        test_stop;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
